// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package riscv_pkg;

    localparam int XLEN = 32;

    // Bootrom base doubles as the reset vector.
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Memory map.
    localparam logic [XLEN-1:0] BOOTROM_BASE = 32'h0000_0000;
    localparam int unsigned     BOOTROM_SIZE = 4096;
    localparam logic [XLEN-1:0] MAINMEM_BASE = 32'h0000_8000;
    localparam int unsigned     MAINMEM_SIZE = 32768;

    // One fetch buffer entry; fault marks a misaligned-fetch entry with no instruction.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            fault;
    } ifetch_entry_t;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        KILL = 1'b1
    } ifetch_state_t;

    // Takes only the two low address bits so callers pass exactly what matters.
    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/riscv_ifetch_if.sv
// Bundle of the fetch unit's memory, redirect and decode handshake signals.
// Latency: n/a (wiring only).
// Backpressure: imem via data_ready, decode via id2if_ready.
interface riscv_ifetch_if;
    import riscv_pkg::*;

    logic            hart2imem_addr_valid;
    logic [XLEN-1:0] hart2imem_addr;
    logic            imem2hart_data_ready;
    logic [XLEN-1:0] imem2hart_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            if2id_valid;
    logic [XLEN-1:0] if2id_pc;
    logic [XLEN-1:0] if2id_instr;
    logic            if2id_fault;
    logic            id2if_ready;

    // Fetch unit side.
    modport master (
        output hart2imem_addr_valid, hart2imem_addr,
        output if2id_valid, if2id_pc, if2id_instr, if2id_fault,
        input  imem2hart_data_ready, imem2hart_data,
        input  redirect_valid, redirect_pc,
        input  id2if_ready
    );

    // Environment side: memory, execute and decode.
    modport slave (
        input  hart2imem_addr_valid, hart2imem_addr,
        input  if2id_valid, if2id_pc, if2id_instr, if2id_fault,
        output imem2hart_data_ready, imem2hart_data,
        output redirect_valid, redirect_pc,
        output id2if_ready
    );

endinterface

// File: rtl/riscv_ifetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; head is read straight from storage.
// Latency: a push is visible at the head the cycle after its edge.
// Backpressure: push is ignored when full, pop ignored when empty; flush wins over pop.
module riscv_ifetch_fifo
    import riscv_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_i,
    input  ifetch_entry_t push_dat_i,
    input  logic          pop_i,
    output logic [CW-1:0] count_o,
    output logic          head_vld_o,
    output ifetch_entry_t head_dat_o
);

    // DEPTH must be a power of two (2 or 4) so the pointers wrap naturally.
    ifetch_entry_t mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    // A flush empties the buffer first, so a push alongside it always has room.
    assign do_push = push_i && (flush_i || (count_q != CW'(DEPTH)));
    assign do_pop  = pop_i && !flush_i && (count_q != '0);

    // Storage, pointers and occupancy; flush restarts at slot 0 and may land one entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            if (do_push) begin
                mem_q[0] <= push_dat_i;
                wr_ptr_q <= PW'(1);
                count_q  <= CW'(1);
            end else begin
                wr_ptr_q <= '0;
                count_q  <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    assign count_o    = count_q;
    assign head_vld_o = (count_q != '0);
    assign head_dat_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/riscv_ifetch.sv
// Instruction fetch: owns the PC, fetches words from imem, buffers them toward decode.
// Latency: beat at edge N is at the decode head after edge N; redirect costs one KILL cycle.
// Backpressure: request valid drops when the buffer is full (registered, no path from id2if_ready).
// Optional feature macro: RISCV_IFETCH_MISALIGN_TRAP_EN (misaligned redirect becomes a fault entry).
module riscv_ifetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    riscv_ifetch_if.master bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    ifetch_state_t   state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            halt_q, halt_d;
    logic            addr_vld_q, addr_vld_d;
    logic [CW-1:0]   count, count_d;
    logic            flush, push, pop;
    logic            head_vld;
    ifetch_entry_t   push_dat, head_dat;
    logic            redir_misaligned;
    logic [XLEN-1:0] redir_pc;

`ifdef RISCV_IFETCH_MISALIGN_TRAP_EN
    assign redir_misaligned = !is_word_aligned(bus.redirect_pc[1:0]);
    assign redir_pc         = bus.redirect_pc;
`else
    // Without the trap feature the low bits are simply dropped.
    assign redir_misaligned = 1'b0;
    assign redir_pc         = bus.redirect_pc & ~XLEN'(3);
`endif

    // Next-state: redirect beats any beat/pop in the same cycle; valid is precomputed from next state.
    always_comb begin
        flush          = 1'b0;
        push           = 1'b0;
        pop            = 1'b0;
        push_dat       = '0;
        pc_d           = pc_q;
        state_d        = RUN;
        halt_d         = halt_q;
        count_d        = count;
        if (bus.redirect_valid) begin
            flush          = 1'b1;
            pc_d           = redir_pc;
            state_d        = KILL;
            halt_d         = redir_misaligned;
            push           = redir_misaligned;
            push_dat.pc    = redir_pc;
            push_dat.instr = '0;
            push_dat.fault = 1'b1;
            count_d        = redir_misaligned ? CW'(1) : '0;
        end else begin
            push           = addr_vld_q && bus.imem2hart_data_ready;
            pop            = head_vld && bus.id2if_ready;
            push_dat.pc    = pc_q;
            push_dat.instr = bus.imem2hart_data;
            push_dat.fault = 1'b0;
            if (push) begin
                pc_d = pc_q + XLEN'(4);
            end
            count_d = count + CW'(push) - CW'(pop);
        end
        addr_vld_d = (state_d == RUN) && !halt_d && (count_d < CW'(FIFO_DEPTH));
    end

    // FSM, PC and the registered request valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            halt_q     <= 1'b0;
            addr_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            halt_q     <= halt_d;
            addr_vld_q <= addr_vld_d;
        end
    end

    riscv_ifetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .count_o    (count),
        .head_vld_o (head_vld),
        .head_dat_o (head_dat)
    );

    assign bus.hart2imem_addr_valid = addr_vld_q;
    assign bus.hart2imem_addr       = pc_q;
    assign bus.if2id_valid          = head_vld;
    assign bus.if2id_pc             = head_dat.pc;
    assign bus.if2id_instr          = head_dat.instr;
    // Only a misaligned redirect ever pushes fault=1, so without the trap feature this stays 0.
    assign bus.if2id_fault          = head_dat.fault;

endmodule

// File: doc/riscv_ifetch.md
# riscv_ifetch

Instruction fetch unit for the single-hart core. Owns the program counter, issues word fetches on the hart instruction-fetch port of the MMU (hart2imem_*), and buffers returned instructions in a small FIFO toward decode with a valid/ready handshake. It accepts PC redirects from execute (branches, jumps, traps) and discards any stale fetches.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset (bootrom base).
- FIFO_DEPTH, 2, fetch buffer entries; legal values are 2 or 4.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- hart2imem_addr_valid  out  1  fetch request valid.
- hart2imem_addr  out  32  fetch word address.
- imem2hart_data_ready  in  1  fetch data valid this cycle.
- imem2hart_data  in  32  fetched instruction word.
- redirect_valid  in  1  execute requests a PC change.
- redirect_pc  in  32  new PC.
- if2id_valid  out  1  buffer head valid.
- if2id_pc  out  32  PC of head instruction.
- if2id_instr  out  32  head instruction word.
- if2id_fault  out  1  head is a misaligned-fetch fault entry.
- id2if_ready  in  1  decode consumes the head this cycle.

## Operation
- State: fetch PC register, FSM {RUN, KILL}, FIFO of {pc, instr, fault} entries, count register.
- Memory protocol: a beat completes on any edge where hart2imem_addr_valid && imem2hart_data_ready. The address is held stable while valid is high until the beat completes. An address may change before completion only after valid has been low for at least one cycle.
- RUN: hart2imem_addr_valid = (count < FIFO_DEPTH), computed from registered state with no combinational path from id2if_ready. On a completed beat, push {pc, imem2hart_data, 0} and set pc <= pc + 4. The add wraps modulo 2^32, so 0xFFFF_FFFC becomes 0x0000_0000.
- On redirect_valid in RUN, all of the following happen:
  - Flush the FIFO (count <= 0).
  - pc <= redirect_pc.
  - Discard any beat completing in the same cycle.
  - Go to KILL.
- KILL: hart2imem_addr_valid = 0 for exactly one cycle, hart2imem_addr shows the new PC, then return to RUN. A redirect arriving in KILL reloads the PC and stays in KILL one more cycle.
- Pop: on if2id_valid && id2if_ready && !redirect_valid, pop the head. Push and pop in the same cycle leaves count unchanged.
- Priority: reset > redirect > push/pop.
- An unmapped PC never receives data_ready. The unit then holds the request indefinitely; the only exits are a redirect or reset.

## Timing
- Reset values:
  - hart2imem_addr_valid = 0, hart2imem_addr = RESET_PC.
  - if2id_valid = 0, if2id_pc = 0, if2id_instr = 0, if2id_fault = 0.
  - FSM = RUN, count = 0.
- First cycle after rst deasserts: addr_valid = 1 with addr = RESET_PC.
- Latency: a beat completing at edge N makes if2id_valid = 1 after edge N. There is no combinational path from imem to if2id.
- Throughput: one instruction per cycle when memory returns data_ready in the same cycle and decode is always ready.
- Full: when count == FIFO_DEPTH, addr_valid is 0 on the next cycle. It reasserts the cycle after a pop.
- Redirect penalty: new-PC data can complete no earlier than 2 cycles after the redirect edge (one KILL cycle plus one request cycle).

## Configuration
- RISCV_IFETCH_MISALIGN_TRAP_EN defined:
  - A redirect with redirect_pc[1:0] != 0 pushes a single entry {redirect_pc, 32'h0, 1} without any memory access.
  - Fetching then halts (addr_valid = 0) until the next redirect.
- Undefined:
  - redirect_pc[1:0] is forced to 0 and fetch proceeds normally.
  - if2id_fault is tied to 0.

## Structure
- riscv_pkg holds:
  - XLEN = 32.
  - RESET_PC default.
  - Memory-map constants: bootrom base 0x0, size 4 KiB; mainmem base 0x8000, size 32 KiB.
  - Packed ifetch_entry_t {pc, instr, fault}.
  - Enum ifetch_state_t {RUN, KILL}.
- One sub-module: riscv_ifetch_fifo, a parameterised synchronous FIFO of ifetch_entry_t with flush, push, pop, count and head outputs.

## Test plan
- Reset release, memory with same-cycle ready, decode always ready:
  - addr sequence is 0x0, 0x4, 0x8, ...
  - if2id_pc trails the fetch address by one cycle.
  - One instruction per cycle.
- id2if_ready held low:
  - Exactly FIFO_DEPTH entries are accepted (pcs 0x0, 0x4), then addr_valid drops.
  - One pop later, addr_valid returns with addr 0x8.
- Redirect to 0x8000 in the same cycle as a completed beat at 0x10:
  - The 0x10 data is never presented on if2id.
  - One KILL cycle follows (addr_valid = 0, addr = 0x8000).
  - The next entry presented has pc 0x8000.
- Memory with 3-cycle ready latency:
  - addr stays stable and valid high until ready.
  - Each instruction appears one cycle after its ready.
- Misaligned redirect to 0x8002:
  - With the macro: one entry {0x8002, 0, fault = 1} is presented, then no fetches.
  - Without the macro: fetch proceeds from 0x8000.
- rst asserted mid-stall with the FIFO full: all outputs return to their reset values asynchronously, and fetch restarts at RESET_PC.
